// File: rtl/sys_bus_ctrl_pkg.sv
// Shared definitions for the system bus controller and its trace path.
package sys_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_ARMED   = 2'd1,
    TR_CAPTURE = 2'd2,
    TR_DONE    = 2'd3
  } trace_state_e;

endpackage

// File: rtl/sys_bus_ctrl_trace_buf.sv
// Trace storage: simple dual-port RAM, synchronous write, registered read.
// No reset on the array or read register so it maps onto block/distributed RAM.
module trace_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sys_bus_ctrl.sv
// System bus controller: priority bus mux, contention detection/latching,
// and a triggered trace buffer captured on CPU ticks.
module sys_bus_ctrl #(
  parameter int DATA_W      = 16,
  parameter int N_SRC       = 4,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           step,
  input  logic [N_SRC-1:0]               src_en,
  input  logic [N_SRC*DATA_W-1:0]        src_data,
  output logic [DATA_W-1:0]              bus,
  output logic [DATA_W-1:0]              bus_q,
  output logic                           contention,
  output logic                           err_sticky,
  output logic [N_SRC-1:0]               err_mask,
  input  logic                           err_clr,
  input  logic                           trace_arm,
  input  logic [DATA_W-1:0]              trig_val,
  input  logic [DATA_W-1:0]              trig_mask,
  output logic [1:0]                     trace_state,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  input  logic                           rd_en,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_valid
);

  import sys_bus_ctrl_pkg::*;

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  trace_state_e       state, state_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_n;
  logic               wr_en;
  logic               rd_fire;
  logic               trig_hit;
  logic [DATA_W-1:0]  ram_q;

  // Priority mux: scan from highest index down so the lowest enabled index wins
  always_comb begin
    bus = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (src_en[i-1]) bus = src_data[(i-1)*DATA_W +: DATA_W];
    end
  end

  // More than one enable high: clearing the lowest set bit leaves something
  assign contention = |(src_en & (src_en - N_SRC'(1)));

  assign trig_hit = ~|((bus ^ trig_val) & trig_mask);

  // Bus sample register and contention latches; a contended step beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q      <= '0;
      err_sticky <= 1'b0;
      err_mask   <= '0;
    end else begin
      if (step) bus_q <= bus;
      if (step && contention) begin
        err_sticky <= 1'b1;
        err_mask   <= err_clr ? src_en : (err_mask | src_en);
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_mask   <= '0;
      end
    end
  end

  // Trace FSM next-state, pointer and count logic
  always_comb begin
    state_n  = state;
    count_n  = count;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    wr_en    = 1'b0;
    rd_fire  = 1'b0;
    unique case (state)
      TR_IDLE: begin
        if (trace_arm) begin
          state_n  = TR_ARMED;
          count_n  = '0;
          wr_ptr_n = '0;
          rd_ptr_n = '0;
        end
      end
      TR_ARMED: begin
        if (step && trig_hit) begin
          wr_en    = 1'b1;
          wr_ptr_n = wr_ptr + PTR_W'(1);
          count_n  = CNT_W'(1);
          state_n  = TR_CAPTURE;
        end
      end
      TR_CAPTURE: begin
        if (step) begin
          wr_en    = 1'b1;
          wr_ptr_n = wr_ptr + PTR_W'(1);
          count_n  = count + CNT_W'(1);
          if (count == CNT_W'(TRACE_DEPTH - 1)) state_n = TR_DONE;
        end
      end
      TR_DONE: begin
        if (trace_arm) begin
          state_n  = TR_ARMED;
          count_n  = '0;
          wr_ptr_n = '0;
          rd_ptr_n = '0;
        end else if (rd_en && count != '0) begin
          rd_fire  = 1'b1;
          rd_ptr_n = rd_ptr + PTR_W'(1);
          count_n  = count - CNT_W'(1);
          if (count == CNT_W'(1)) state_n = TR_IDLE;
        end
      end
      default: ;
    endcase
  end

  // Trace FSM state, pointers, count and read-valid strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TR_IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      rd_valid <= rd_fire;
    end
  end

  trace_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus),
    .re    (rd_fire),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // RAM read register has no reset; gate so rd_data reads zero outside a pop
  assign rd_data     = rd_valid ? ram_q : '0;
  assign trace_state = state;
  assign trace_count = count;

endmodule
